// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of an external PWM input and reports duty as a level 0..9.
// Latency: valid_o fires 10 cycles after the closing rising edge; no backpressure, results are one-cycle pulses.
module pwm_duty_decoder #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwm_i,
  output logic [3:0] duty_level_o,
  output logic       valid_o,
  output logic       timeout_o
);

  localparam int               CW      = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, MEAS, CALC, DONE, TOUT} state_t;
  state_t state;

  logic             pwm_m, pwm_s, pwm_s_d;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CW-1:0]    h18, thr, thr_inc;
  logic [3:0]       step, lvl, lvl_nxt;
  logic             rise, hit, to_hit, enter_tout;

  assign rise       = pwm_s & ~pwm_s_d;
  assign hit        = (h18 >= thr);
  assign lvl_nxt    = lvl + {3'b000, hit};
  // Fires on the cycle whose increment brings per_cnt to TIMEOUT.
  assign to_hit     = (per_cnt == TO_LAST);
  assign enter_tout = ((state == IDLE) || (state == MEAS)) && !rise && to_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pwm_m        <= 1'b0;
      pwm_s        <= 1'b0;
      pwm_s_d      <= 1'b0;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      h18          <= '0;
      thr          <= '0;
      thr_inc      <= '0;
      step         <= '0;
      lvl          <= '0;
      duty_level_o <= '0;
      valid_o      <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      pwm_m   <= pwm_i;
      pwm_s   <= pwm_m;
      pwm_s_d <= pwm_s;
      valid_o <= 1'b0;

      // A rise in any state starts a new period; in CALC/DONE that drops the in-flight one.
      if (rise) begin
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
        if (pwm_s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (rise) state <= MEAS;
        end
        MEAS: begin
          if (rise) begin
            h18     <= (CW'(hi_cnt) << 4) + (CW'(hi_cnt) << 1);
            thr     <= CW'(per_cnt);
            thr_inc <= CW'(per_cnt) << 1;
            lvl     <= '0;
            step    <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          // Step k compares 18*H against (2k-1)*P; H >= P passes all nine steps.
          lvl  <= lvl_nxt;
          thr  <= thr + thr_inc;
          step <= step + 4'd1;
          if (step == 4'd8) begin
            duty_level_o <= lvl_nxt;
            timeout_o    <= 1'b0;
            valid_o      <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: state <= MEAS;
        TOUT: begin
          per_cnt <= '0;
          hi_cnt  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_tout) begin
        duty_level_o <= pwm_s ? 4'd9 : 4'd0;
        timeout_o    <= 1'b1;
        valid_o      <= 1'b1;
        state        <= TOUT;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: table of PWM shapes plus flat-line and mid-CALC reset sequences.
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       pwm_i = 1'b0;
  logic [3:0] duty_level_o;
  logic       valid_o;
  logic       timeout_o;

  always #5 clk = ~clk;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .pwm_i       (pwm_i),
    .duty_level_o(duty_level_o),
    .valid_o     (valid_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    int period;
    int high;
    int lvl;
    int cnt;
  } vec_t;

  vec_t vecs[12];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vcyc[$];
  int   vlev[$];
  int   vto[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic p, input logic r);
    @(negedge clk);
    cyc++;
    if (valid_o === 1'b1) begin
      vcyc.push_back(cyc);
      vlev.push_back(int'(duty_level_o));
      vto.push_back(int'(timeout_o));
    end
    pwm_i = p;
    rst_i = r;
  endtask

  task automatic clear_q();
    vcyc.delete();
    vlev.delete();
    vto.delete();
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    clear_q();
  endtask

  task automatic wave(input int per, input int hi, input int nper);
    for (int n = 0; n < nper; n++)
      for (int i = 0; i < per; i++)
        tick(i < hi, 1'b0);
  endtask

  initial begin
    int r0;
    int last_hi;

    vecs[0]  = '{10, 5, 5, 2};
    vecs[1]  = '{100, 50, 5, 3};
    vecs[2]  = '{100, 49, 4, 3};
    vecs[3]  = '{6, 3, 5, 2};
    vecs[4]  = '{20, 1, 0, 3};
    vecs[5]  = '{20, 19, 9, 3};
    vecs[6]  = '{40, 13, 3, 3};
    vecs[7]  = '{50, 36, 6, 3};
    vecs[8]  = '{33, 25, 7, 3};
    vecs[9]  = '{12, 1, 1, 3};
    vecs[10] = '{64, 57, 8, 3};
    vecs[11] = '{30, 7, 2, 3};

    do_reset();
    chk("reset_level", int'(duty_level_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_timeout", int'(timeout_o), 0);

    // Measured periods: the first rise only arms, later rises close periods.
    foreach (vecs[v]) begin
      do_reset();
      repeat (5) tick(1'b0, 1'b0);
      r0 = cyc + 1;
      wave(vecs[v].period, vecs[v].high, 4);
      repeat (40) tick(1'b0, 1'b0);
      chk($sformatf("v%0d_count", v), vcyc.size(), vecs[v].cnt);
      if (vcyc.size() > 0)
        chk($sformatf("v%0d_first_cycle", v), vcyc[0], r0 + vecs[v].period + 12);
      foreach (vlev[i]) begin
        chk($sformatf("v%0d_level%0d", v, i), vlev[i], vecs[v].lvl);
        chk($sformatf("v%0d_tout%0d", v, i), vto[i], 0);
      end
    end

    // Flat high, then flat low: timeout results every TIMEOUT+1 cycles.
    do_reset();
    for (int i = 0; i < 3 * TIMEOUT + 50; i++) begin
      if (vcyc.size() >= 3) break;
      tick(1'b1, 1'b0);
    end
    chk("flat_hi_count", vcyc.size(), 3);
    foreach (vlev[i]) begin
      chk($sformatf("flat_hi_level%0d", i), vlev[i], 9);
      chk($sformatf("flat_hi_tout%0d", i), vto[i], 1);
      if (i > 0) chk($sformatf("flat_hi_gap%0d", i), vcyc[i] - vcyc[i-1], TIMEOUT + 1);
    end
    last_hi = (vcyc.size() > 0) ? vcyc[vcyc.size()-1] : 0;
    clear_q();
    repeat (5) tick(1'b0, 1'b0);
    chk("hold_level", int'(duty_level_o), 9);
    chk("hold_tout", int'(timeout_o), 1);
    chk("hold_valid", int'(valid_o), 0);
    for (int i = 0; i < 3 * TIMEOUT + 50; i++) begin
      if (vcyc.size() >= 2) break;
      tick(1'b0, 1'b0);
    end
    chk("flat_lo_count", vcyc.size(), 2);
    foreach (vlev[i]) begin
      chk($sformatf("flat_lo_level%0d", i), vlev[i], 0);
      chk($sformatf("flat_lo_tout%0d", i), vto[i], 1);
    end
    if (vcyc.size() >= 2) begin
      chk("flat_lo_gap0", vcyc[0] - last_hi, TIMEOUT + 1);
      chk("flat_lo_gap1", vcyc[1] - vcyc[0], TIMEOUT + 1);
    end

    // Reset while CALC is in flight: outputs clear, aborted result never appears.
    do_reset();
    repeat (5) tick(1'b0, 1'b0);
    r0 = cyc + 1;
    wave(40, 20, 2);
    for (int i = 80; i < 120; i++) begin
      tick(i < 100, (i >= 85) && (i < 105));
      if (i == 86) begin
        chk("pre_rst_count", vcyc.size(), 1);
        if (vlev.size() > 0) chk("pre_rst_level", vlev[0], 5);
        chk("rst_calc_level", int'(duty_level_o), 0);
        chk("rst_calc_valid", int'(valid_o), 0);
        chk("rst_calc_tout", int'(timeout_o), 0);
        clear_q();
      end
    end
    wave(40, 20, 3);
    repeat (20) tick(1'b0, 1'b0);
    chk("post_rst_count", vcyc.size(), 2);
    if (vcyc.size() > 0) begin
      chk("post_rst_first_cycle", vcyc[0], r0 + 172);
      chk("post_rst_level", vlev[0], 5);
      chk("post_rst_tout", vto[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
